// File: rtl/batcher_sched_pkg.sv
// rtl/batcher_sched_pkg.sv - shared sizing, types and helpers for the Batcher issue scheduler
// Purpose: lane count, widths, the scheduler state enum, lane masks and the framing record
//          carried alongside the sorter. BATCHER_SIZE / BATCHER_DWIDTH may be predefined to
//          resize the crossbar; defaults are 8 lanes of 8 bits.
// Ports:   none (package).
`ifndef BATCHER_SIZE
`define BATCHER_SIZE 8
`endif
`ifndef BATCHER_DWIDTH
`define BATCHER_DWIDTH 8
`endif

package batcher_sched_pkg;
   localparam int SIZE     = `BATCHER_SIZE;
   localparam int DWIDTH   = `BATCHER_DWIDTH;
   localparam int TAGWIDTH = $clog2(SIZE);
   localparam int LATENCY  = 4;
   localparam int ID_W     = 4;
   localparam int ROUND_W  = $clog2(SIZE) + 1;

   typedef enum logic {IDLE, ISSUE} sched_state_e;

   typedef logic [SIZE-1:0] lane_mask_t;

   typedef struct packed {
      logic            valid;
      lane_mask_t      mask;
      logic [ID_W-1:0] id;
      logic            last;
   } sched_frame_t;

   function automatic logic [31:0] popcount(input lane_mask_t m);
      popcount = '0;
      for (int i = 0; i < SIZE; i++)
         popcount = popcount + 32'(m[i]);
   endfunction
endpackage

// File: rtl/batcher_sched_if.sv
// rtl/batcher_sched_if.sv - batch input, sorter drive and output framing bundle
// Purpose: groups the batch handshake, the sorter inputs and the aligned round framing.
// Ports (slave = scheduler side):
//   in_valid/in_ready/in_lane_en/in_dest/in_data  batch offer and accept
//   xb_din/xb_shift                               sorter data and tag inputs
//   out_valid/out_lane_mask/out_batch_id/out_last framing aligned to sorter output
interface batcher_sched_if;
   import batcher_sched_pkg::*;

   logic                       in_valid;
   logic                       in_ready;
   lane_mask_t                 in_lane_en;
   logic [SIZE*TAGWIDTH-1:0]   in_dest;
   logic [SIZE*DWIDTH-1:0]     in_data;
   logic [SIZE*DWIDTH-1:0]     xb_din;
   logic [SIZE*TAGWIDTH-1:0]   xb_shift;
   logic                       out_valid;
   lane_mask_t                 out_lane_mask;
   logic [ID_W-1:0]            out_batch_id;
   logic                       out_last;

   modport master (
      output in_valid, in_lane_en, in_dest, in_data,
      input  in_ready, xb_din, xb_shift, out_valid, out_lane_mask, out_batch_id, out_last
   );

   modport slave (
      input  in_valid, in_lane_en, in_dest, in_data,
      output in_ready, xb_din, xb_shift, out_valid, out_lane_mask, out_batch_id, out_last
   );
endinterface

// File: rtl/dest_conflict_resolve.sv
// rtl/dest_conflict_resolve.sv - per-destination lowest-lane grant for one issue round
// Purpose: combinational; among pending lanes, the lowest-index lane per destination is
//          granted and every other pending lane with the same destination is a loser.
// Ports:
//   pending  in   lanes still waiting to issue
//   dest     in   destination tag per lane
//   grant    out  lanes issued this round (unique destinations)
//   loser    out  pending lanes held back by a lower-index lane with the same destination
module dest_conflict_resolve
   import batcher_sched_pkg::*;
(
   input  lane_mask_t                 pending,
   input  logic [SIZE*TAGWIDTH-1:0]   dest,
   output lane_mask_t                 grant,
   output lane_mask_t                 loser
);
   logic blocked;

   always_comb begin
      grant   = '0;
      loser   = '0;
      blocked = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < i; j++)
            if (pending[j] && (dest[j*TAGWIDTH +: TAGWIDTH] == dest[i*TAGWIDTH +: TAGWIDTH]))
               blocked = 1'b1;
         grant[i] = pending[i] & ~blocked;
         loser[i] = pending[i] & blocked;
      end
   end
endmodule

// File: rtl/batcher_sched.sv
// rtl/batcher_sched.sv - conflict-free round issue scheduler for the Batcher-sort crossbar
// Purpose: accepts a batch of lane requests, splits it into rounds with unique destinations,
//          drives one round per cycle into the sorter and delays the round framing by the
//          sorter latency. Optional BATCHER_SCHED_STATS_EN adds batch/round/conflict counters.
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   flush          drop pending rounds and kill in-flight framing; blocks accept
//   bus            batcher_sched_if.slave (batch input, sorter drive, output framing)
//   stat_*         (BATCHER_SCHED_STATS_EN only) completed batches, issued rounds, conflicts
module batcher_sched
   import batcher_sched_pkg::*;
(
   input  logic               clk,
   input  logic               n_rst,
   input  logic               flush,
   batcher_sched_if.slave     bus
`ifdef BATCHER_SCHED_STATS_EN
   ,
   output logic [31:0]        stat_batches,
   output logic [31:0]        stat_rounds,
   output logic [31:0]        stat_conflicts
`endif
);
   sched_state_e              state;
   logic                      ready_q;
   lane_mask_t                pending_q;
   logic [SIZE*DWIDTH-1:0]    data_q;
   logic [SIZE*TAGWIDTH-1:0]  dest_q;
   logic [ID_W-1:0]           batch_id;
   logic [ROUND_W-1:0]        round_cnt;

   logic                      accept;
   logic                      issue_valid;
   logic                      round_last;
   lane_mask_t                cur_pending;
   lane_mask_t                grant;
   lane_mask_t                loser;
   logic [SIZE*DWIDTH-1:0]    cur_data;
   logic [SIZE*TAGWIDTH-1:0]  cur_dest;
   sched_frame_t              frame_in;
   sched_frame_t              frame_out;

   assign bus.in_ready = ready_q & ~flush;
   assign accept       = bus.in_valid & bus.in_ready;
   // n_rst gate keeps the sorter inputs quiet while reset holds in_ready high.
   assign issue_valid  = n_rst & ((state == ISSUE) ? ~flush : accept);
   // Losers are exactly what remains pending after this round.
   assign round_last   = ~|loser;

   // Round 0 is issued straight from the input in the accept cycle.
   always_comb begin
      cur_pending = '0;
      cur_data    = data_q;
      cur_dest    = dest_q;
      if (state == IDLE) begin
         cur_data = bus.in_data;
         cur_dest = bus.in_dest;
      end
      if (issue_valid)
         cur_pending = (state == IDLE) ? bus.in_lane_en : pending_q;
   end

   dest_conflict_resolve u_resolve (
      .pending (cur_pending),
      .dest    (cur_dest),
      .grant   (grant),
      .loser   (loser)
   );

   always_comb begin
      bus.xb_din   = '0;
      bus.xb_shift = '0;
      for (int i = 0; i < SIZE; i++)
         if (grant[i]) begin
            bus.xb_din[i*DWIDTH +: DWIDTH]       = cur_data[i*DWIDTH +: DWIDTH];
            bus.xb_shift[i*TAGWIDTH +: TAGWIDTH] = cur_dest[i*TAGWIDTH +: TAGWIDTH];
         end
   end

   always_comb begin
      frame_in = '0;
      if (issue_valid) begin
         frame_in.valid = 1'b1;
         frame_in.mask  = grant;
         frame_in.id    = batch_id;
         frame_in.last  = round_last;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         ready_q   <= 1'b1;
         pending_q <= '0;
         data_q    <= '0;
         dest_q    <= '0;
         batch_id  <= '0;
         round_cnt <= '0;
      end else if (flush) begin
         state     <= IDLE;
         ready_q   <= 1'b1;
         pending_q <= '0;
         round_cnt <= '0;
      end else if (issue_valid) begin
         if (state == IDLE) begin
            data_q <= bus.in_data;
            dest_q <= bus.in_dest;
         end
         pending_q <= loser;
         if (round_last) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            round_cnt <= '0;
            batch_id  <= batch_id + 1'b1;
         end else begin
            state     <= ISSUE;
            ready_q   <= 1'b0;
            round_cnt <= round_cnt + 1'b1;
         end
      end
   end

   // Each round retires at least one lane, so a batch can never need more than SIZE rounds.
   always_ff @(posedge clk) begin
      if (issue_valid)
         assert (round_cnt < ROUND_W'(SIZE));
   end

   generate
      if (LATENCY == 0) begin : g_comb
         assign frame_out = frame_in;
      end else begin : g_pipe
         sched_frame_t pipe [LATENCY];
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
            end else if (flush) begin
               for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= frame_in;
               for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign frame_out = pipe[LATENCY-1];
      end
   endgenerate

   assign bus.out_valid     = frame_out.valid;
   assign bus.out_lane_mask = frame_out.mask;
   assign bus.out_batch_id  = frame_out.id;
   assign bus.out_last      = frame_out.last;

`ifdef BATCHER_SCHED_STATS_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stat_batches   <= '0;
         stat_rounds    <= '0;
         stat_conflicts <= '0;
      end else if (issue_valid) begin
         if (round_last && (stat_batches != '1)) stat_batches <= stat_batches + 32'd1;
         if (stat_rounds != '1)                  stat_rounds  <= stat_rounds + 32'd1;
         stat_conflicts <= stat_conflicts + popcount(loser);
      end
   end
`endif
endmodule

// File: tb/tb_batcher_sched.sv
// tb/tb_batcher_sched.sv - directed self-checking bench for batcher_sched (SIZE=8, LATENCY=4)
module tb_batcher_sched;
   import batcher_sched_pkg::*;

   logic clk = 1'b0;
   logic n_rst;
   logic flush;
   always #5 clk = ~clk;

   batcher_sched_if bus();

`ifdef BATCHER_SCHED_STATS_EN
   logic [31:0] stat_batches, stat_rounds, stat_conflicts;
`endif

   batcher_sched dut (
      .clk   (clk),
      .n_rst (n_rst),
      .flush (flush),
      .bus   (bus)
`ifdef BATCHER_SCHED_STATS_EN
      ,
      .stat_batches   (stat_batches),
      .stat_rounds    (stat_rounds),
      .stat_conflicts (stat_conflicts)
`endif
   );

   int n_vec = 0;
   int n_err = 0;
   sched_frame_t             eq [LATENCY];
   logic [ID_W-1:0]          eid;
   lane_mask_t               epend;
   logic [SIZE*DWIDTH-1:0]   cur_data;
   logic [SIZE*TAGWIDTH-1:0] cur_dest;
   int e_batches = 0, e_rounds = 0, e_conf = 0;
   logic [SIZE*TAGWIDTH-1:0] d;
   logic [SIZE*DWIDTH-1:0]   x;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic v, input lane_mask_t en,
                        input logic [SIZE*TAGWIDTH-1:0] dst, input logic [SIZE*DWIDTH-1:0] dat);
      bus.in_valid   = v;
      bus.in_lane_en = en;
      bus.in_dest    = dst;
      bus.in_data    = dat;
   endtask

   // One clock cycle: acc = batch taken this cycle, rdy = expected in_ready,
   // ev/emask/elast = round expected to be issued this cycle.
   task automatic cyc(input logic acc, input logic rdy, input logic ev,
                      input lane_mask_t emask, input logic elast);
      logic [SIZE*DWIDTH-1:0]   xd;
      logic [SIZE*TAGWIDTH-1:0] xs;
      lane_mask_t               lose;
      sched_frame_t             f;
      if (acc) begin
         cur_data = bus.in_data;
         cur_dest = bus.in_dest;
         epend    = bus.in_lane_en;
      end
      #3;
      chk("in_ready", 64'(bus.in_ready), 64'(rdy));
      xd = '0;
      xs = '0;
      for (int i = 0; i < SIZE; i++)
         if (emask[i]) begin
            xd[i*DWIDTH +: DWIDTH]     = cur_data[i*DWIDTH +: DWIDTH];
            xs[i*TAGWIDTH +: TAGWIDTH] = cur_dest[i*TAGWIDTH +: TAGWIDTH];
         end
      chk("xb_din", 64'(bus.xb_din), 64'(xd));
      chk("xb_shift", 64'(bus.xb_shift), 64'(xs));
      chk("out_valid", 64'(bus.out_valid), 64'(eq[LATENCY-1].valid));
      chk("out_lane_mask", 64'(bus.out_lane_mask), 64'(eq[LATENCY-1].mask));
      chk("out_batch_id", 64'(bus.out_batch_id), 64'(eq[LATENCY-1].id));
      chk("out_last", 64'(bus.out_last), 64'(eq[LATENCY-1].last));
      f = '0;
      if (ev) begin
         f.valid = 1'b1;
         f.mask  = emask;
         f.id    = eid;
         f.last  = elast;
         lose    = epend & ~emask;
         e_rounds++;
         e_conf += $countones(lose);
         epend = lose;
         if (elast) begin
            eid++;
            e_batches++;
         end
      end
      @(posedge clk);
      #1;
      for (int i = LATENCY-1; i > 0; i--) eq[i] = eq[i-1];
      eq[0] = f;
      if (flush) begin
         for (int i = 0; i < LATENCY; i++) eq[i] = '0;
         epend = '0;
      end
   endtask

   initial begin
      for (int i = 0; i < LATENCY; i++) eq[i] = '0;
      eid      = '0;
      epend    = '0;
      cur_data = '0;
      cur_dest = '0;
      n_rst    = 1'b0;
      flush    = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         d[i*TAGWIDTH +: TAGWIDTH] = TAGWIDTH'(SIZE-1-i);
         x[i*DWIDTH +: DWIDTH]     = DWIDTH'(8'h10 + i);
      end
      offer(1'b1, 8'hFF, d, x);
      @(posedge clk);
      #1;

      // Reset held with a batch offered: nothing issued, outputs idle.
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      n_rst = 1'b1;
      offer(1'b0, 8'h00, '0, '0);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Permutation: single round, in_ready stays high.
      offer(1'b1, 8'hFF, d, x);
      cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
      offer(1'b0, 8'h00, '0, '0);
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Full conflict: all lanes to dest 3, eight single-lane rounds.
      for (int i = 0; i < SIZE; i++) begin
         d[i*TAGWIDTH +: TAGWIDTH] = TAGWIDTH'(3);
         x[i*DWIDTH +: DWIDTH]     = DWIDTH'(8'h20 + i);
      end
      offer(1'b1, 8'hFF, d, x);
      cyc(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
      offer(1'b0, 8'h00, '0, '0);
      for (int k = 1; k < 8; k++) cyc(1'b0, 1'b0, 1'b1, lane_mask_t'(1 << k), (k == 7));
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Partial: lanes 0..3 to dests 1,1,2,2 (idle lanes also tagged 1), then back-to-back batch.
      d = '0;
      for (int i = 0; i < SIZE; i++) begin
         d[i*TAGWIDTH +: TAGWIDTH] = (i == 2 || i == 3) ? TAGWIDTH'(2) : TAGWIDTH'(1);
         x[i*DWIDTH +: DWIDTH]     = DWIDTH'(8'h30 + i);
      end
      offer(1'b1, 8'h0F, d, x);
      cyc(1'b1, 1'b1, 1'b1, 8'h05, 1'b0);
      d = '0;
      d[0 +: TAGWIDTH]        = TAGWIDTH'(5);
      d[TAGWIDTH +: TAGWIDTH] = TAGWIDTH'(6);
      offer(1'b1, 8'h03, d, 64'h5555_5555_5555_B2A1);
      cyc(1'b0, 1'b0, 1'b1, 8'h0A, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 8'h03, 1'b1);
      offer(1'b0, 8'h00, '0, '0);
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Flush at round 2 of a full-conflict batch; flush also blocks a same-cycle offer.
      for (int i = 0; i < SIZE; i++) begin
         d[i*TAGWIDTH +: TAGWIDTH] = TAGWIDTH'(3);
         x[i*DWIDTH +: DWIDTH]     = DWIDTH'(8'h40 + i);
      end
      offer(1'b1, 8'hFF, d, x);
      cyc(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
      offer(1'b0, 8'h00, '0, '0);
      cyc(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
      flush = 1'b1;
      offer(1'b1, 8'h00, '0, 64'h0123_4567_89AB_CDEF);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      flush = 1'b0;

      // Empty batch right after the flush: one round, mask 0, last.
      cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
      offer(1'b0, 8'h00, '0, '0);
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

`ifdef BATCHER_SCHED_STATS_EN
      chk("stat_batches", 64'(stat_batches), 64'(e_batches));
      chk("stat_rounds", 64'(stat_rounds), 64'(e_rounds));
      chk("stat_conflicts", 64'(stat_conflicts), 64'(e_conf));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
